// File: rtl/osd_spi_master.sv
// ============================================================================
//  Module      : osd_spi_master
//  Description : Transmitting end of the OSD SPI link. Accepts one command per
//                valid/ready handshake, frames the command byte (and, for a
//                line write, 256 payload bytes fetched from a synchronous
//                buffer) onto SPI_SCK / SPI_SS3 / SPI_DO, MSB first.
//  Ports       : clk_sys, reset            - clock, async active-high reset
//                cmd_valid/cmd_ready       - command handshake
//                cmd_op, cmd_line          - 0 dis, 1 en, 2 write line, 3 nop
//                busy                      - frame, tail or gap in progress
//                data_rd, data_addr,
//                data_in                   - payload buffer (1-cycle latency)
//                SPI_SCK, SPI_SS3, SPI_DO  - SPI master outputs
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module osd_spi_master #(
    parameter int CLK_DIV = 4,   // SCK half-period in clk_sys cycles (2..255)
    parameter int SS_GAP  = 2    // SS3-high time after a frame, in CLK_DIV units
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [2:0]  cmd_line,
    output logic        busy,
    output logic        data_rd,
    output logic [10:0] data_addr,
    input  logic [7:0]  data_in,
    output logic        SPI_SCK,
    output logic        SPI_SS3,
    output logic        SPI_DO
);

    localparam logic [7:0] C_DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0] C_GAP_LAST  = 8'(SS_GAP - 1);
    localparam logic [8:0] C_LAST_BYTE = 9'd256;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_TAIL  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;        // cycles within the current half-period
    logic [7:0]  gap_q, gap_d;        // CLK_DIV units spent in GAP
    logic [7:0]  shift_q, shift_d;    // byte being shifted out
    logic [7:0]  pref_q, pref_d;      // prefetched next payload byte
    logic [8:0]  byte_q, byte_d;      // 0 = command, 1..256 = payload
    logic [2:0]  bit_q, bit_d;        // bit index within the byte, 7 downto 0
    logic        write_q, write_d;
    logic [2:0]  line_q, line_d;
    logic        rd_dly_q, rd_dly_d;  // data_in is valid while this is set
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        sck_q, sck_d;
    logic        ss_q, ss_d;
    logic        do_q, do_d;
    logic        rd_q, rd_d;
    logic [10:0] addr_q, addr_d;

    logic        w_div_end;
    logic [7:0]  w_next_byte;
    logic [7:0]  w_cmd_byte;

    assign w_div_end = (div_q == C_DIV_LAST);

    // With CLK_DIV == 2 the capture cycle coincides with the SCK fall, so the
    // shifter loads straight from data_in in that cycle.
    assign w_next_byte = rd_dly_q ? data_in : pref_q;

    assign w_cmd_byte = (cmd_op == 2'd2) ? {5'b00100, cmd_line}
                                         : {7'b0100000, cmd_op[0]};

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        gap_d    = gap_q;
        shift_d  = shift_q;
        pref_d   = pref_q;
        byte_d   = byte_q;
        bit_d    = bit_q;
        write_d  = write_q;
        line_d   = line_q;
        rd_dly_d = rd_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        sck_d    = sck_q;
        ss_d     = ss_q;
        do_d     = do_q;
        rd_d     = 1'b0;
        addr_d   = addr_q;

        if (rd_dly_q) begin
            pref_d = data_in;
        end

        case (state_q)
            S_IDLE: begin
                // A no-op is consumed by the handshake alone.
                if (cmd_valid && (cmd_op != 2'd3)) begin
                    state_d = S_SHIFT;
                    ss_d    = 1'b0;
                    sck_d   = 1'b0;
                    div_d   = 8'd0;
                    bit_d   = 3'd7;
                    byte_d  = 9'd0;
                    write_d = (cmd_op == 2'd2);
                    line_d  = cmd_line;
                    shift_d = w_cmd_byte;
                    do_d    = w_cmd_byte[7];
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            S_SHIFT: begin
                div_d = div_q + 8'd1;
                if (w_div_end) begin
                    div_d = 8'd0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        // Fetch the next payload byte while the LSB is high.
                        if ((bit_q == 3'd0) && write_q && (byte_q != C_LAST_BYTE)) begin
                            rd_d   = 1'b1;
                            addr_d = {line_q, byte_q[7:0]};
                        end
                    end else begin
                        sck_d = 1'b0;
                        if (bit_q != 3'd0) begin
                            shift_d = {shift_q[6:0], 1'b0};
                            do_d    = shift_q[6];
                            bit_d   = bit_q - 3'd1;
                        end else if (write_q && (byte_q != C_LAST_BYTE)) begin
                            shift_d = w_next_byte;
                            do_d    = w_next_byte[7];
                            bit_d   = 3'd7;
                            byte_d  = byte_q + 9'd1;
                        end else begin
                            state_d = S_TAIL;
                        end
                    end
                end
            end

            S_TAIL: begin
                div_d = div_q + 8'd1;
                if (w_div_end) begin
                    div_d   = 8'd0;
                    gap_d   = 8'd0;
                    ss_d    = 1'b1;
                    do_d    = 1'b0;
                    state_d = S_GAP;
                end
            end

            S_GAP: begin
                div_d = div_q + 8'd1;
                if (w_div_end) begin
                    div_d = 8'd0;
                    gap_d = gap_q + 8'd1;
                    if (gap_q == C_GAP_LAST) begin
                        state_d = S_IDLE;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            div_q    <= 8'd0;
            gap_q    <= 8'd0;
            shift_q  <= 8'd0;
            pref_q   <= 8'd0;
            byte_q   <= 9'd0;
            bit_q    <= 3'd0;
            write_q  <= 1'b0;
            line_q   <= 3'd0;
            rd_dly_q <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            sck_q    <= 1'b0;
            ss_q     <= 1'b1;
            do_q     <= 1'b0;
            rd_q     <= 1'b0;
            addr_q   <= 11'd0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            gap_q    <= gap_d;
            shift_q  <= shift_d;
            pref_q   <= pref_d;
            byte_q   <= byte_d;
            bit_q    <= bit_d;
            write_q  <= write_d;
            line_q   <= line_d;
            rd_dly_q <= rd_dly_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            sck_q    <= sck_d;
            ss_q     <= ss_d;
            do_q     <= do_d;
            rd_q     <= rd_d;
            addr_q   <= addr_d;
        end
    end

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign data_rd   = rd_q;
    assign data_addr = addr_q;
    assign SPI_SCK   = sck_q;
    assign SPI_SS3   = ss_q;
    assign SPI_DO    = do_q;

endmodule

`default_nettype wire

// File: tb/tb_osd_spi_master.sv
// ============================================================================
//  Module      : tb_osd_spi_master
//  Description : Self-checking bench for osd_spi_master. Expected SPI bytes and
//                payload read addresses are queued when a command is issued
//                and popped as the SPI and buffer monitors observe them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_osd_spi_master;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_line;
    logic        busy;
    logic        data_rd;
    logic [10:0] data_addr;
    logic [7:0]  data_in;
    logic        SPI_SCK, SPI_SS3, SPI_DO;

    // Second instance with CLK_DIV = 3
    logic        c3_valid;
    logic        c3_ready;
    logic [1:0]  c3_op;
    logic        c3_busy;
    logic        c3_rd;
    logic [10:0] c3_addr;
    logic [7:0]  c3_din;
    logic        c3_sck, c3_ss, c3_do;

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    osd_spi_master #(.CLK_DIV(2), .SS_GAP(2)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_line(cmd_line), .busy(busy),
        .data_rd(data_rd), .data_addr(data_addr), .data_in(data_in),
        .SPI_SCK(SPI_SCK), .SPI_SS3(SPI_SS3), .SPI_DO(SPI_DO)
    );

    osd_spi_master #(.CLK_DIV(3), .SS_GAP(2)) dut3 (
        .clk_sys(clk_sys), .reset(reset),
        .cmd_valid(c3_valid), .cmd_ready(c3_ready),
        .cmd_op(c3_op), .cmd_line(3'd0), .busy(c3_busy),
        .data_rd(c3_rd), .data_addr(c3_addr), .data_in(c3_din),
        .SPI_SCK(c3_sck), .SPI_SS3(c3_ss), .SPI_DO(c3_do)
    );

    // Payload buffer: byte i of any line is i ^ 0xA5, one cycle after data_rd.
    always @(posedge clk_sys) data_in <= data_rd ? (data_addr[7:0] ^ 8'hA5) : 8'hFF;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    logic [7:0]  exp_bytes[$];
    logic [10:0] exp_addr[$];

    task automatic push_frame(input logic [1:0] op, input logic [2:0] line);
        logic [7:0] b;
        case (op)
            2'd0: exp_bytes.push_back(8'h40);
            2'd1: exp_bytes.push_back(8'h41);
            2'd2: begin
                exp_bytes.push_back({5'b00100, line});
                for (int i = 0; i < 256; i++) begin
                    b = 8'(i);
                    exp_bytes.push_back(b ^ 8'hA5);
                    exp_addr.push_back({line, b});
                end
            end
            default: ;
        endcase
    endtask

    // ---------------- monitor (samples mid-cycle) ----------------
    logic       prev_sck = 1'b0, prev_ss = 1'b1, prev_do = 1'b0;
    logic       prev_busy = 1'b0, prev_rdy = 1'b1;
    logic [7:0] rx = 8'd0;
    int nbits = 0, bytes_rx = 0, rises = 0, rd_cnt = 0;
    int first_rise = 0, last_rise = 0, ss_fall_cyc = 0, ss_rise_cyc = 0;
    int ss_falls = 0, gap_len = 0, busy_rise = 0, busy_fall = 0, rdy_rise = 0;
    int do_viol = 0, stray = 0;

    always @(negedge clk_sys) begin
        if (!reset) begin
            if (prev_ss && !SPI_SS3) begin
                ss_fall_cyc = cyc;
                ss_falls++;
                gap_len = cyc - ss_rise_cyc;
                rises = 0;
                nbits = 0;
                rd_cnt = 0;
            end
            if (!prev_ss && SPI_SS3) ss_rise_cyc = cyc;
            if (!prev_sck && SPI_SCK) begin
                if (SPI_SS3) stray++;
                else begin
                    if (rises == 0) first_rise = cyc;
                    last_rise = cyc;
                    rises++;
                    rx = {rx[6:0], SPI_DO};
                    nbits++;
                    if (nbits == 8) begin
                        nbits = 0;
                        bytes_rx++;
                        if (exp_bytes.size() == 0) check_eq("byte_unexpected", 32'(exp_bytes.size()), 32'd1);
                        else check_eq("spi_byte", {24'd0, rx}, {24'd0, exp_bytes.pop_front()});
                    end
                end
            end
            if (prev_sck && SPI_SCK && (SPI_DO != prev_do)) do_viol++;
            if (data_rd) begin
                rd_cnt++;
                if (exp_addr.size() == 0) check_eq("rd_unexpected", 32'(exp_addr.size()), 32'd1);
                else check_eq("rd_addr", {21'd0, data_addr}, {21'd0, exp_addr.pop_front()});
            end
            if (!prev_busy && busy) busy_rise = cyc;
            if (prev_busy && !busy) busy_fall = cyc;
            if (!prev_rdy && cmd_ready) rdy_rise = cyc;
        end
        prev_sck  = SPI_SCK;
        prev_ss   = SPI_SS3;
        prev_do   = SPI_DO;
        prev_busy = busy;
        prev_rdy  = cmd_ready;
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] line, output int a);
        int guard = 0;
        cmd_op = op;
        cmd_line = line;
        cmd_valid = 1'b1;
        while (!cmd_ready && guard < 20000) begin step(); guard++; end
        check_eq("issue_ready", cmd_ready, 1);
        a = cyc;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (!cmd_ready && guard < 20000) begin step(); guard++; end
        check_eq("idle_wait", cmd_ready, 1);
        step();
    endtask

    // Timing expectations for CLK_DIV = 2, SS_GAP = 2.
    task automatic check_frame(input int a, input int nb, input int nrd);
        check_eq("ss_fall", ss_fall_cyc, a + 1);
        check_eq("ss_rise", ss_rise_cyc, a + 1 + (2 * nb + 1) * 2);
        check_eq("first_rise", first_rise, a + 3);
        check_eq("last_rise", last_rise, a + 3 + 4 * (nb - 1));
        check_eq("sck_rises", rises, nb);
        check_eq("ready_return", rdy_rise, a + 1 + (2 * nb + 3) * 2);
        check_eq("busy_rise", busy_rise, a + 1);
        check_eq("busy_fall", busy_fall, a + 1 + (2 * nb + 3) * 2);
        check_eq("rd_pulses", rd_cnt, nrd);
        check_eq("do_stable_high", do_viol, 0);
        check_eq("stray_sck", stray, 0);
        check_eq("bytes_left", exp_bytes.size(), 0);
        check_eq("addr_left", exp_addr.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int a, a2, base, guard, falls0;
        int r0, r1, nr, ss3r, rdy3, nrd3;
        logic p_sck, p_ss, p_rdy;
        logic [7:0] rx3;

        reset = 1'b1;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_line = 3'd0;
        c3_valid = 1'b0; c3_op = 2'd0; c3_din = 8'd0;
        #12;
        check_eq("rst_ss", SPI_SS3, 1);
        check_eq("rst_sck", SPI_SCK, 0);
        check_eq("rst_do", SPI_DO, 0);
        check_eq("rst_rd", data_rd, 0);
        check_eq("rst_addr", data_addr, 0);
        check_eq("rst_busy", busy, 0);
        step(); step();
        reset = 1'b0;
        step();
        check_eq("rst_ready", cmd_ready, 1);

        // op1
        push_frame(2'd1, 3'd0);
        issue(2'd1, 3'd0, a);
        wait_idle();
        check_frame(a, 8, 0);

        // op0
        push_frame(2'd0, 3'd0);
        issue(2'd0, 3'd0, a);
        wait_idle();
        check_frame(a, 8, 0);

        // op2 on line 5
        push_frame(2'd2, 3'd5);
        issue(2'd2, 3'd5, a);
        wait_idle();
        check_frame(a, 2056, 256);

        // back-to-back: valid held high, op changes after first accept
        push_frame(2'd1, 3'd0);
        push_frame(2'd0, 3'd0);
        cmd_op = 2'd1; cmd_valid = 1'b1;
        check_eq("b2b_ready0", cmd_ready, 1);
        a = cyc;
        step();
        cmd_op = 2'd0;
        guard = 0;
        while (!cmd_ready && guard < 200) begin step(); guard++; end
        a2 = cyc;
        check_eq("b2b_accept", a2, a + 39);
        step();
        cmd_valid = 1'b0;
        check_eq("b2b_ss_low", SPI_SS3, 0);
        wait_idle();
        check_eq("b2b_gap", gap_len >= 4, 1);
        check_frame(a2, 8, 0);

        // reset in the middle of payload byte 100
        push_frame(2'd2, 3'd5);
        base = bytes_rx;
        issue(2'd2, 3'd5, a);
        guard = 0;
        while (bytes_rx < base + 101 && guard < 20000) begin step(); guard++; end
        check_eq("midrst_reach", bytes_rx >= base + 101, 1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("midrst_ss", SPI_SS3, 1);
        check_eq("midrst_sck", SPI_SCK, 0);
        check_eq("midrst_do", SPI_DO, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_rd", data_rd, 0);
        exp_bytes.delete();
        exp_addr.delete();
        step(); step();
        reset = 1'b0;
        step();
        check_eq("midrst_ready", cmd_ready, 1);
        push_frame(2'd1, 3'd0);
        issue(2'd1, 3'd0, a);
        wait_idle();
        check_frame(a, 8, 0);

        // op3: consumed by the handshake, no SPI activity
        falls0 = ss_falls;
        issue(2'd3, 3'd0, a);
        check_eq("nop_ready", cmd_ready, 1);
        check_eq("nop_busy", busy, 0);
        check_eq("nop_ss", SPI_SS3, 1);
        repeat (10) step();
        check_eq("nop_no_frame", ss_falls, falls0);

        // CLK_DIV = 3 instance, op1
        check_eq("c3_ready_idle", c3_ready, 1);
        c3_op = 2'd1; c3_valid = 1'b1;
        a = cyc;
        step();
        c3_valid = 1'b0;
        check_eq("c3_busy", c3_busy, 1);
        check_eq("c3_ss_low", c3_ss, 0);
        p_sck = c3_sck; p_ss = c3_ss; p_rdy = c3_ready;
        r0 = 0; r1 = 0; nr = 0; ss3r = 0; rdy3 = 0; nrd3 = 0; rx3 = 8'd0;
        for (int k = 0; k < 80; k++) begin
            step();
            if (c3_sck && !p_sck) begin
                if (nr == 0) r0 = cyc;
                if (nr == 1) r1 = cyc;
                nr++;
                if (!c3_ss) rx3 = {rx3[6:0], c3_do};
            end
            if (c3_ss && !p_ss && ss3r == 0) ss3r = cyc;
            if (c3_ready && !p_rdy && rdy3 == 0) rdy3 = cyc;
            if (c3_rd) nrd3++;
            p_sck = c3_sck; p_ss = c3_ss; p_rdy = c3_ready;
        end
        check_eq("c3_first_rise", r0, a + 4);
        check_eq("c3_period", r1 - r0, 6);
        check_eq("c3_rises", nr, 8);
        check_eq("c3_byte", rx3, 8'h41);
        check_eq("c3_ss_rise", ss3r, a + 52);
        check_eq("c3_ready", rdy3, a + 58);
        check_eq("c3_no_rd", nrd3, 0);
        check_eq("c3_addr", c3_addr, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
